// File: rtl/am_tx_keyer.sv
// -----------------------------------------------------------------------------
// am_tx_keyer
//
// Transmit-keying controller for one AM TX channel. It drives the AM
// modulator's depth (module_deep) and carrier word (center_fre). On push-to-talk
// it slews the depth up to the programmed target, and on release it slews the
// depth back to zero so that the carrier is keyed without clicks. The target
// depth and carrier word are reconfigured over a valid/ready handshake.
//
// Optional feature macro: AM_HANG_EN
//   Defined   : releasing PTT while ON first holds the depth for HANG_CYCLES
//               cycles (HANG state). Re-keying in that window returns to ON
//               without any ramp.
//   Undefined : ON goes straight to RAMP_DOWN on PTT release. HANG_CYCLES has
//               no effect.
//
// Ports
//   clk_in       in   1            system clock
//   RST_N        in   1            synchronous reset, active low
//   ptt          in   1            push-to-talk level, synchronous to clk_in
//   cfg_valid    in   1            config word valid
//   cfg_ready    out  1            config accepted when cfg_valid & cfg_ready
//   cfg_deep     in   16           new target depth
//   cfg_fre      in   PHASE_WIDTH  new carrier frequency word
//   ramp_div     in   DIV_WIDTH    ramp tick every ramp_div+1 cycles
//   ramp_step    in   16           depth change per tick (0 acts as 1)
//   module_deep  out  16           depth to modulator, registered
//   center_fre   out  PHASE_WIDTH  carrier word to modulator, registered
//   tx_active    out  1            high whenever the state is not IDLE
//   state_o      out  3            state encoding, for debug
//                                  (IDLE=0 SLEW=1 ON=2 RAMP_DOWN=3 HANG=4)
// -----------------------------------------------------------------------------
module am_tx_keyer #(
  parameter int unsigned             PHASE_WIDTH  = 32,
  parameter int unsigned             DIV_WIDTH    = 16,
  parameter logic [15:0]             DEFAULT_DEEP = 16'd32768,
  parameter logic [PHASE_WIDTH-1:0]  DEFAULT_FRE  = PHASE_WIDTH'(229780750),
  parameter int unsigned             HANG_CYCLES  = 1024
) (
  input  logic                   clk_in,
  input  logic                   RST_N,
  input  logic                   ptt,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [15:0]            cfg_deep,
  input  logic [PHASE_WIDTH-1:0] cfg_fre,
  input  logic [DIV_WIDTH-1:0]   ramp_div,
  input  logic [15:0]            ramp_step,
  output logic [15:0]            module_deep,
  output logic [PHASE_WIDTH-1:0] center_fre,
  output logic                   tx_active,
  output logic [2:0]             state_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SLEW = 3'd1,
    ST_ON   = 3'd2,
    ST_DOWN = 3'd3,
    ST_HANG = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [15:0]            deep_q, deep_d;
  logic [15:0]            target_q;
  logic [PHASE_WIDTH-1:0] fre_q;
  logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   active_q;

  logic                   xfer;
  logic                   counting;
  logic                   tick;
  logic [15:0]            step_eff;
  logic [16:0]            up_sum;
  logic [15:0]            up_val;
  logic [15:0]            dn_to_target;
  logic [15:0]            dn_to_zero;

`ifdef AM_HANG_EN
  localparam int unsigned     HANG_W    = $clog2(HANG_CYCLES + 1);
  localparam logic [HANG_W-1:0] HANG_LAST = HANG_W'(HANG_CYCLES - 1);
  logic [HANG_W-1:0] hcnt_q, hcnt_d;
`else
  // Keeps the parameter referenced in builds without the hang state.
  logic unused_hang;
  assign unused_hang = (HANG_CYCLES != 0);
`endif

  // Config is only taken while the depth is settled (IDLE or ON), and never
  // while reset is asserted.
  assign cfg_ready = RST_N && ((state_q == ST_IDLE) || (state_q == ST_ON));
  assign xfer      = cfg_valid && cfg_ready;

  assign step_eff  = (ramp_step == 16'd0) ? 16'd1 : ramp_step;
  assign counting  = (state_q == ST_SLEW) || (state_q == ST_DOWN);
  assign tick      = counting && (cnt_q == ramp_div);

  // Upward slew is summed at 17 bits so a large step saturates at the target
  // instead of wrapping past 65535.
  assign up_sum       = {1'b0, deep_q} + {1'b0, step_eff};
  assign up_val       = (up_sum >= {1'b0, target_q}) ? target_q : up_sum[15:0];
  // Only used when deep_q > target_q, so the difference cannot underflow.
  assign dn_to_target = ((deep_q - target_q) <= step_eff) ? target_q
                                                          : (deep_q - step_eff);
  assign dn_to_zero   = (deep_q <= step_eff) ? 16'd0 : (deep_q - step_eff);

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    deep_d  = deep_q;

    case (state_q)
      ST_IDLE: begin
        deep_d = '0;
        if (ptt) state_d = ST_SLEW;
      end

      // The depth only moves on a tick while the state is kept; any state
      // change freezes it for that cycle.
      ST_SLEW: begin
        if (!ptt) begin
          state_d = ST_DOWN;
        end else if (deep_q == target_q) begin
          state_d = ST_ON;
        end else if (tick) begin
          deep_d = (deep_q < target_q) ? up_val : dn_to_target;
        end
      end

      ST_ON: begin
        if (!ptt) begin
`ifdef AM_HANG_EN
          state_d = ST_HANG;
`else
          state_d = ST_DOWN;
`endif
        end else if (xfer && (cfg_deep != deep_q)) begin
          state_d = ST_SLEW;
        end
      end

      // Re-keying resumes the slew from the current depth, without a jump.
      ST_DOWN: begin
        if (ptt) begin
          state_d = ST_SLEW;
        end else if (deep_q == 16'd0) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          deep_d = dn_to_zero;
        end
      end

`ifdef AM_HANG_EN
      ST_HANG: begin
        if (ptt) begin
          state_d = ST_ON;
        end else if (hcnt_q == HANG_LAST) begin
          state_d = ST_DOWN;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
        deep_d  = '0;
      end
    endcase

    // Prescaler restarts on every state change so each ramp segment begins
    // with a full ramp_div+1 period.
    if ((state_d != state_q) || !counting || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

`ifdef AM_HANG_EN
  assign hcnt_d = ((state_q == ST_HANG) && (state_d == ST_HANG)) ? (hcnt_q + 1'b1)
                                                                 : '0;
`endif

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the values from before the edge.
  always_ff @(posedge clk_in) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      deep_q   <= '0;
      target_q <= DEFAULT_DEEP;
      fre_q    <= DEFAULT_FRE;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      deep_q   <= deep_d;
      cnt_q    <= cnt_d;
      active_q <= (state_d != ST_IDLE);
      // The carrier word is applied at once; the downstream NCO keeps its
      // accumulator, so the change stays phase-continuous.
      if (xfer) begin
        target_q <= cfg_deep;
        fre_q    <= cfg_fre;
      end
    end
  end

`ifdef AM_HANG_EN
  always_ff @(posedge clk_in) begin
    if (!RST_N) hcnt_q <= '0;
    else        hcnt_q <= hcnt_d;
  end
`endif

  assign module_deep = deep_q;
  assign center_fre  = fre_q;
  assign tx_active   = active_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_am_tx_keyer.sv
// -----------------------------------------------------------------------------
// tb_am_tx_keyer
//
// Self-checking bench for am_tx_keyer: a constant-expectation vector table
// (reset and depth saturation), hand-written multi-cycle sequences (ramp
// up/down, reversal, reconfiguration in ON, hang window, mid-run reset, zero
// step) and a randomized run, all compared every cycle against a behavioural
// model of the keyer.
// -----------------------------------------------------------------------------
module tb_am_tx_keyer;

  localparam logic [31:0] DEF_FRE  = 32'd229780750;
  localparam int          DEF_DEEP = 32768;
  localparam int          HANG     = 10;

  localparam int S_IDLE = 0;
  localparam int S_SLEW = 1;
  localparam int S_ON   = 2;
  localparam int S_DOWN = 3;
  localparam int S_HANG = 4;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        ptt;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_deep;
  logic [31:0] cfg_fre;
  logic [15:0] ramp_div;
  logic [15:0] ramp_step;
  logic [15:0] module_deep;
  logic [31:0] center_fre;
  logic        tx_active;
  logic [2:0]  state_o;

  am_tx_keyer #(
    .PHASE_WIDTH (32),
    .DIV_WIDTH   (16),
    .DEFAULT_DEEP(16'd32768),
    .DEFAULT_FRE (DEF_FRE),
    .HANG_CYCLES (HANG)
  ) dut (
    .clk_in     (clk_in),
    .RST_N      (rst_n),
    .ptt        (ptt),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_deep   (cfg_deep),
    .cfg_fre    (cfg_fre),
    .ramp_div   (ramp_div),
    .ramp_step  (ramp_step),
    .module_deep(module_deep),
    .center_fre (center_fre),
    .tx_active  (tx_active),
    .state_o    (state_o)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;
  int cyc_no   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: depth as a plain integer moved by min/max arithmetic,
  // a tick every ramp_div+1 cycles of a ramping phase, and the keying rules.
  // ---------------------------------------------------------------------------
  int          m_state  = S_IDLE;
  int          m_deep   = 0;
  int          m_target = DEF_DEEP;
  logic [31:0] m_fre    = DEF_FRE;
  int          m_cnt    = 0;
  int          m_hcnt   = 0;
  bit          m_active = 1'b0;

  function automatic bit m_ready();
    return rst_n && (m_state == S_IDLE || m_state == S_ON);
  endfunction

  task automatic model_step();
    int nx;
    int nd;
    int stp;
    bit xfer;
    bit ramping;
    bit tick;
    xfer = cfg_valid && m_ready();
    if (!rst_n) begin
      m_state  = S_IDLE;
      m_deep   = 0;
      m_target = DEF_DEEP;
      m_fre    = DEF_FRE;
      m_cnt    = 0;
      m_hcnt   = 0;
      m_active = 1'b0;
      return;
    end
    stp     = (ramp_step == 0) ? 1 : int'(ramp_step);
    ramping = (m_state == S_SLEW || m_state == S_DOWN);
    tick    = ramping && (m_cnt == int'(ramp_div));
    nx      = m_state;
    nd      = m_deep;
    case (m_state)
      S_IDLE: begin
        nd = 0;
        if (ptt) nx = S_SLEW;
      end
      S_SLEW: begin
        if (!ptt) nx = S_DOWN;
        else if (m_deep == m_target) nx = S_ON;
        else if (tick) begin
          if (m_deep < m_target) nd = (m_deep + stp > m_target) ? m_target : m_deep + stp;
          else                   nd = (m_deep - stp < m_target) ? m_target : m_deep - stp;
        end
      end
      S_ON: begin
`ifdef AM_HANG_EN
        if (!ptt) nx = S_HANG;
`else
        if (!ptt) nx = S_DOWN;
`endif
        else if (xfer && int'(cfg_deep) != m_deep) nx = S_SLEW;
      end
      S_DOWN: begin
        if (ptt) nx = S_SLEW;
        else if (m_deep == 0) nx = S_IDLE;
        else if (tick) nd = (m_deep - stp < 0) ? 0 : m_deep - stp;
      end
      S_HANG: begin
        if (ptt) nx = S_ON;
        else if (m_hcnt == HANG - 1) nx = S_DOWN;
      end
      default: nx = S_IDLE;
    endcase
    if (nx != m_state || !ramping || tick) m_cnt = 0;
    else m_cnt = m_cnt + 1;
    m_hcnt   = (m_state == S_HANG && nx == S_HANG) ? m_hcnt + 1 : 0;
    if (xfer) begin
      m_target = int'(cfg_deep);
      m_fre    = cfg_fre;
    end
    m_state  = nx;
    m_deep   = nd;
    m_active = (nx != S_IDLE);
  endtask

  always @(posedge clk_in) model_step();

  // One clock: inputs already set; outputs sampled on the falling edge.
  task automatic cyc();
    @(posedge clk_in);
    @(negedge clk_in);
    cyc_no++;
    check($sformatf("c%0d deep", cyc_no),   module_deep, m_deep);
    check($sformatf("c%0d fre", cyc_no),    center_fre,  m_fre);
    check($sformatf("c%0d active", cyc_no), tx_active,   m_active);
    check($sformatf("c%0d state", cyc_no),  state_o,     m_state);
    check($sformatf("c%0d ready", cyc_no),  cfg_ready,   m_ready());
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0; ptt = 1'b0; cfg_valid = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  // ---------------------------------------------------------------------------
  // Constant-expectation vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          rst_n;
    bit          ptt;
    bit          vld;
    logic [15:0] cd;
    logic [31:0] cf;
    logic [15:0] div;
    logic [15:0] step;
    int          e_deep;
    int          e_state;
    logic [31:0] e_fre;
    bit          e_act;
    bit          e_rdy;
  } vec_t;

`ifdef AM_HANG_EN
  localparam int N_TAB = 8;
`else
  localparam int N_TAB = 12;
`endif

  vec_t tab [12];

  initial begin
    int pick;
    tab[0]  = '{1'b0, 1'b0, 1'b0, 16'd0,     32'd0,   16'd0, 16'd1,     0,     S_IDLE, DEF_FRE, 1'b0, 1'b0};
    tab[1]  = '{1'b0, 1'b0, 1'b0, 16'd0,     32'd0,   16'd0, 16'd1,     0,     S_IDLE, DEF_FRE, 1'b0, 1'b0};
    tab[2]  = '{1'b0, 1'b0, 1'b0, 16'd0,     32'd0,   16'd0, 16'd1,     0,     S_IDLE, DEF_FRE, 1'b0, 1'b0};
    tab[3]  = '{1'b1, 1'b0, 1'b0, 16'd0,     32'd0,   16'd0, 16'd1,     0,     S_IDLE, DEF_FRE, 1'b0, 1'b1};
    tab[4]  = '{1'b1, 1'b1, 1'b1, 16'd65535, 32'd777, 16'd0, 16'd40000, 0,     S_SLEW, 32'd777, 1'b1, 1'b0};
    tab[5]  = '{1'b1, 1'b1, 1'b0, 16'd0,     32'd0,   16'd0, 16'd40000, 40000, S_SLEW, 32'd777, 1'b1, 1'b0};
    tab[6]  = '{1'b1, 1'b1, 1'b0, 16'd0,     32'd0,   16'd0, 16'd40000, 65535, S_SLEW, 32'd777, 1'b1, 1'b0};
    tab[7]  = '{1'b1, 1'b1, 1'b0, 16'd0,     32'd0,   16'd0, 16'd40000, 65535, S_ON,   32'd777, 1'b1, 1'b1};
    tab[8]  = '{1'b1, 1'b0, 1'b0, 16'd0,     32'd0,   16'd0, 16'd40000, 65535, S_DOWN, 32'd777, 1'b1, 1'b0};
    tab[9]  = '{1'b1, 1'b0, 1'b0, 16'd0,     32'd0,   16'd0, 16'd40000, 25535, S_DOWN, 32'd777, 1'b1, 1'b0};
    tab[10] = '{1'b1, 1'b0, 1'b0, 16'd0,     32'd0,   16'd0, 16'd40000, 0,     S_DOWN, 32'd777, 1'b1, 1'b0};
    tab[11] = '{1'b1, 1'b0, 1'b0, 16'd0,     32'd0,   16'd0, 16'd40000, 0,     S_IDLE, 32'd777, 1'b0, 1'b1};

    rst_n = 1'b0; ptt = 1'b0; cfg_valid = 1'b0;
    cfg_deep = '0; cfg_fre = '0; ramp_div = '0; ramp_step = 16'd1;

    // Reset and saturation vectors.
    for (int i = 0; i < N_TAB; i++) begin
      rst_n = tab[i].rst_n; ptt = tab[i].ptt; cfg_valid = tab[i].vld;
      cfg_deep = tab[i].cd; cfg_fre = tab[i].cf;
      ramp_div = tab[i].div; ramp_step = tab[i].step;
      cyc();
      check($sformatf("tab%0d deep", i),   module_deep, tab[i].e_deep);
      check($sformatf("tab%0d state", i),  state_o,     tab[i].e_state);
      check($sformatf("tab%0d fre", i),    center_fre,  tab[i].e_fre);
      check($sformatf("tab%0d active", i), tx_active,   tab[i].e_act);
      check($sformatf("tab%0d ready", i),  cfg_ready,   tab[i].e_rdy);
    end
    cfg_valid = 1'b0;

    // Ramp up to the default target in 8192 steps every 4 cycles, then down.
    reset_pulse();
    ramp_div = 16'd3; ramp_step = 16'd8192; ptt = 1'b1;
    cyc();
    check("up entry state", state_o, S_SLEW);
    for (int k = 1; k <= 17; k++) begin
      cyc();
      if (k % 4 == 0) check($sformatf("up k%0d deep", k), module_deep, 8192 * (k / 4));
    end
    check("up on state", state_o, S_ON);
    ptt = 1'b0;
`ifdef AM_HANG_EN
    repeat (HANG) cyc();
`endif
    cyc();
    check("down entry state", state_o, S_DOWN);
    check("down entry deep", module_deep, 32768);
    for (int k = 1; k <= 17; k++) begin
      cyc();
      if (k % 4 == 0) check($sformatf("down k%0d deep", k), module_deep, 32768 - 8192 * (k / 4));
    end
    check("down idle state", state_o, S_IDLE);
    check("down idle active", tx_active, 1'b0);

    // Reversal: drop PTT at 16384 while slewing, re-key at 8192.
    ptt = 1'b1;
    repeat (9) cyc();
    check("rev slew deep", module_deep, 16384);
    ptt = 1'b0;
    cyc();
    check("rev down state", state_o, S_DOWN);
    check("rev down deep", module_deep, 16384);
    repeat (4) cyc();
    check("rev mid deep", module_deep, 8192);
    ptt = 1'b1;
    cyc();
    check("rev reslew state", state_o, S_SLEW);
    check("rev reslew deep", module_deep, 8192);
    repeat (4) cyc();
    check("rev up deep", module_deep, 16384);
    repeat (9) cyc();
    check("rev on state", state_o, S_ON);
    check("rev on deep", module_deep, 32768);

    // Reconfiguration while ON.
    cfg_valid = 1'b1; cfg_deep = 16'd16384; cfg_fre = 32'd100;
    cyc();
    cfg_valid = 1'b0;
    check("recfg fre", center_fre, 100);
    check("recfg state", state_o, S_SLEW);
    check("recfg ready", cfg_ready, 1'b0);
    repeat (4) cyc();
    check("recfg mid deep", module_deep, 24576);
    repeat (4) cyc();
    check("recfg end deep", module_deep, 16384);
    cyc();
    check("recfg on state", state_o, S_ON);

`ifdef AM_HANG_EN
    // Hang window: short release returns to ON, long release ramps down.
    ptt = 1'b0;
    repeat (5) cyc();
    check("hang short state", state_o, S_HANG);
    check("hang ready", cfg_ready, 1'b0);
    ptt = 1'b1;
    cyc();
    check("hang rekey state", state_o, S_ON);
    check("hang rekey deep", module_deep, 16384);
    ptt = 1'b0;
    repeat (10) cyc();
    check("hang long state", state_o, S_HANG);
    cyc();
    check("hang expire state", state_o, S_DOWN);
    check("hang expire deep", module_deep, 16384);
    ptt = 1'b1;
    repeat (3) cyc();
`endif

    // Mid-operation reset returns outputs at once, no ramp.
    repeat (3) cyc();
    rst_n = 1'b0;
    cyc();
    check("midrst deep", module_deep, 0);
    check("midrst state", state_o, S_IDLE);
    check("midrst fre", center_fre, DEF_FRE);
    check("midrst active", tx_active, 1'b0);
    check("midrst ready", cfg_ready, 1'b0);
    ptt = 1'b0; rst_n = 1'b1;
    cyc();

    // Zero step behaves as a step of one.
    ramp_div = 16'd0; ramp_step = 16'd0; ptt = 1'b1;
    cyc();
    cyc();
    check("step0 first", module_deep, 1);
    cyc();
    check("step0 second", module_deep, 2);
    reset_pulse();

    // Randomized run against the model.
    ramp_div = 16'd1; ramp_step = 16'd12000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) ptt = ~ptt;
      rst_n     = ($urandom_range(0, 499) != 0);
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_deep  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      cfg_fre   = $urandom;
      if ((m_state == S_IDLE || m_state == S_ON) && $urandom_range(0, 9) == 0) begin
        ramp_div  = 16'($urandom_range(0, 3));
        pick      = $urandom_range(0, 7);
        ramp_step = (pick == 0) ? 16'd0 : 16'($urandom_range(256, 40000));
      end
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
